// File: rtl/sub_8_gate_pkg.sv
// ----------------------------------------------------------------------------
// sub8_pkg
// Shared definitions for the 8-bit gate-level ripple-borrow subtractor.
//   SUB8_W        : operand / result width (fixed at 8)
//   sub8_result_t : difference plus borrow-out, used for the registered copy
// ----------------------------------------------------------------------------
package sub8_pkg;

    localparam int SUB8_W = 8;

    typedef struct packed {
        logic [SUB8_W-1:0] d;
        logic              bout;
    } sub8_result_t;

endpackage

// File: rtl/sub_8_gate_if.sv
// ----------------------------------------------------------------------------
// sub_8_gate_if
// Operand / result bundle for sub_8_gate.
//   A, B      : minuend and subtrahend (driven by master)
//   D, BOUT   : combinational difference and borrow-out (driven by slave)
//   D_REG,
//   BOUT_REG  : clocked copy of D / BOUT (driven by slave)
// ----------------------------------------------------------------------------
interface sub_8_gate_if;
    import sub8_pkg::*;

    logic [SUB8_W-1:0] A;
    logic [SUB8_W-1:0] B;
    logic [SUB8_W-1:0] D;
    logic              BOUT;
    logic [SUB8_W-1:0] D_REG;
    logic              BOUT_REG;

    modport master (
        output A, B,
        input  D, BOUT, D_REG, BOUT_REG
    );

    modport slave (
        input  A, B,
        output D, BOUT, D_REG, BOUT_REG
    );

endinterface

// File: rtl/sub_8_gate_fsub1.sv
// ----------------------------------------------------------------------------
// fsub1_gate
// One-bit full subtractor built only from single-gate continuous assigns.
//   a, b : operand bits (computes a - b - bin)
//   bin  : borrow in
//   d    : difference bit   = a ^ b ^ bin
//   bout : borrow out       = (~a & b) | (~(a ^ b) & bin)
// ----------------------------------------------------------------------------
module fsub1_gate (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic aXorB;
    logic notA;
    logic notAXorB;
    logic genBorrow;
    logic propBorrow;

    assign aXorB      = a ^ b;
    assign d          = aXorB ^ bin;
    assign notA       = ~a;
    assign genBorrow  = notA & b;
    // Equal operand bits pass the incoming borrow straight through.
    assign notAXorB   = ~aXorB;
    assign propBorrow = notAXorB & bin;
    assign bout       = genBorrow | propBorrow;

endmodule

// File: rtl/sub_8_gate.sv
// ----------------------------------------------------------------------------
// sub_8_gate
// 8-bit unsigned ripple-borrow subtractor, D = (A - B) mod 256, BOUT = A < B,
// plus a registered copy of both for synchronous consumers.
//   clk   : rising-edge clock for the registered copy only
//   rst_n : asynchronous active-low reset of D_REG / BOUT_REG
//   bus   : sub_8_gate_if slave (A, B in; D, BOUT, D_REG, BOUT_REG out)
// D and BOUT are purely combinational and keep tracking A/B during reset.
// ----------------------------------------------------------------------------
module sub_8_gate
    import sub8_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    sub_8_gate_if.slave  bus
);

    logic [SUB8_W:0]   borrowChain;
    logic [SUB8_W-1:0] diffBits;
    sub8_result_t      resultReg;

    assign borrowChain[0] = 1'b0;

    // Borrow ripples LSB to MSB; borrowChain[SUB8_W] is the final borrow-out.
    for (genvar i = 0; i < SUB8_W; i++) begin : gCell
        fsub1_gate uCell (
            .a    (bus.A[i]),
            .b    (bus.B[i]),
            .bin  (borrowChain[i]),
            .d    (diffBits[i]),
            .bout (borrowChain[i+1])
        );
    end

    assign bus.D    = diffBits;
    assign bus.BOUT = borrowChain[SUB8_W];

    // Register stage: capture every cycle, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultReg <= '0;
        end else begin
            resultReg <= '{d: diffBits, bout: borrowChain[SUB8_W]};
        end
    end

    assign bus.D_REG    = resultReg.d;
    assign bus.BOUT_REG = resultReg.bout;

endmodule

// File: tb/tb_sub_8_gate.sv
// ----------------------------------------------------------------------------
// tb_sub_8_gate
// Self-checking bench for sub_8_gate: directed corner cases, random vectors,
// an exhaustive operand sweep and the registered/reset path, all compared
// against an arithmetic reference model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sub_8_gate;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sub_8_gate_if bus ();

    sub_8_gate dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {borrow, difference} from plain integer arithmetic.
    function automatic logic [8:0] refSub(input int a, input int b);
        int diff;
        diff = (a - b) & 255;
        return {(a < b), diff[7:0]};
    endfunction

    task automatic check9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyComb(input logic [7:0] a, input logic [7:0] b, input string tag);
        bus.A = a;
        bus.B = b;
        #1;
        check9(tag, {bus.BOUT, bus.D}, refSub(int'(a), int'(b)));
    endtask

    logic [7:0] dirA [10] = '{8'h00, 8'h10, 8'h80, 8'h00, 8'h7F, 8'h10, 8'h01, 8'hFF, 8'hA5, 8'h5A};
    logic [7:0] dirB [10] = '{8'h00, 8'h10, 8'h80, 8'h01, 8'h80, 8'h1F, 8'h00, 8'h01, 8'h5A, 8'hA5};
    logic [8:0] dirExp[10] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 9'h1FF, 9'h1F1, 9'h001, 9'h0FE, 9'h04B, 9'h1B5};

    initial begin
        logic [7:0] ra, rb;
        logic [8:0] expReg;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.A    = 8'h00;
        bus.B    = 8'h00;

        // Reset held: register cleared despite clocks, D still tracks inputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.A = 8'h33;
        bus.B = 8'h44;
        @(posedge clk);
        #1;
        check9("reset_reg", {bus.BOUT_REG, bus.D_REG}, 9'h000);
        check9("reset_comb", {bus.BOUT, bus.D}, refSub(8'h33, 8'h44));

        // Directed corners: model and hand-computed constants must agree.
        for (int i = 0; i < 10; i++) begin
            bus.A = dirA[i];
            bus.B = dirB[i];
            #1;
            check9($sformatf("dir%0d_const", i), {bus.BOUT, bus.D}, dirExp[i]);
            check9($sformatf("dir%0d_model", i), {bus.BOUT, bus.D}, refSub(int'(dirA[i]), int'(dirB[i])));
        end

        // Release reset and capture 0x5A - 0xA5.
        @(negedge clk);
        rst_n = 1'b1;
        bus.A = 8'h5A;
        bus.B = 8'hA5;
        @(posedge clk);
        #1;
        check9("reg_first", {bus.BOUT_REG, bus.D_REG}, 9'h1B5);

        // Asynchronous reset between edges clears immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check9("async_clr", {bus.BOUT_REG, bus.D_REG}, 9'h000);
        check9("async_comb", {bus.BOUT, bus.D}, 9'h1B5);
        @(negedge clk);
        rst_n = 1'b1;
        bus.A = 8'h01;
        bus.B = 8'h02;
        #1;
        check9("post_rel_hold", {bus.BOUT_REG, bus.D_REG}, 9'h000);
        @(posedge clk);
        #1;
        check9("recapture", {bus.BOUT_REG, bus.D_REG}, 9'h1FF);

        // Random registered stream: each edge captures the value applied before it.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            bus.A = ra;
            bus.B = rb;
            expReg = refSub(int'(ra), int'(rb));
            #1;
            check9($sformatf("rnd%0d_comb", i), {bus.BOUT, bus.D}, expReg);
            @(posedge clk);
            #1;
            check9($sformatf("rnd%0d_reg", i), {bus.BOUT_REG, bus.D_REG}, expReg);
        end

        // Exhaustive combinational sweep.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                applyComb(8'(a), 8'(b), $sformatf("sweep_%02h_%02h", a, b));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
